// File: rtl/cnn_layer_accel_pkg.sv
// cnn_layer_accel_pkg: shared widths, sequence-word fields, loader FSM states and clog2
package cnn_layer_accel_pkg;
  localparam int PIXEL_WIDTH = 16;
  localparam int SEQ_DATA_WIDTH = 13;
  localparam int BRAM_DEPTH = 1024;
  localparam int NUM_AWE = 4;
  localparam int SEQ_DATA_SEQ_FIELD_HI = 9;
  localparam int SEQ_DATA_SEQ_FIELD_LO = 0;
  localparam int SEQ_DATA_PARITY_BIT = 10;
  localparam int SEQ_DATA_RST_BIT = 11;
  localparam int SEQ_DATA_RM_BIT = 12;
  typedef enum logic [1:0] {IDLE, SEQ, PIX, DONE} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/cnn_octo_sdp_bram.sv
// cnn_octo_sdp_bram: simple dual-port ram, one write port, registered read returning old data on collision
module cnn_octo_sdp_bram
  import cnn_layer_accel_pkg::*;
#(
  parameter int W = PIXEL_WIDTH,
  parameter int D = BRAM_DEPTH,
  localparam int AW = clog2(D)
) (
  input  logic          clk_500MHz,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);
  logic [W-1:0] mem [D];
  always_ff @(posedge clk_500MHz)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk_500MHz or posedge rst)
    if (rst) rd <= '0;
    else rd <= mem[ra];
endmodule

// File: rtl/cnn_octo_map_loader.sv
// cnn_octo_map_loader: loads tagged sequence words then a pixel map into buffers with row/map events
module cnn_octo_map_loader
  import cnn_layer_accel_pkg::*;
#(
  parameter int C_NUM_AWE = NUM_AWE,
  parameter int C_PIXEL_WIDTH = PIXEL_WIDTH,
  parameter int C_BRAM_DEPTH = BRAM_DEPTH,
  parameter int C_SEQ_DATA_WIDTH = SEQ_DATA_WIDTH,
  localparam int AW = clog2(C_BRAM_DEPTH)
) (
  input  logic                        clk_500MHz,
  input  logic                        rst,
  input  logic                        new_map,
  input  logic [15:0]                 num_input_rows_cfg,
  input  logic [15:0]                 num_input_cols_cfg,
  input  logic [15:0]                 num_output_rows_cfg,
  input  logic [15:0]                 num_output_cols_cfg,
  input  logic [15:0]                 seq_full_count_cfg,
  input  logic [15:0]                 row_matric_done_count_cfg,
  input  logic                        pixel_datain_tag,
  output logic                        pixel_datain_rdy,
  input  logic                        seq_datain_tag,
  output logic                        seq_datain_rdy,
  input  logic [C_PIXEL_WIDTH-1:0]    datain,
  input  logic                        datain_valid,
  output logic                        row_done,
  output logic                        map_loaded,
  input  logic [AW-1:0]               seq_rd_addr,
  output logic [C_SEQ_DATA_WIDTH-1:0] seq_rd_data,
  input  logic [AW-1:0]               pix_rd_addr,
  output logic [C_PIXEL_WIDTH-1:0]    pix_rd_data,
  output logic [31:0]                 cfg_out
);
  state_t state, state_n;
  logic [15:0] seq_cnt, pix_cnt, col_cnt, seq_full_q, row_len_q, out_rows_q, out_cols_q;
  logic [15:0] seq_cnt_n, pix_cnt_n, col_inc, seq_nxt, pix_nxt;
  logic [31:0] pix_total_q;
  logic seq_acc, pix_acc, row_hit, seq_rdy_n, pix_rdy_n;
  assign seq_acc = datain_valid & seq_datain_tag & seq_datain_rdy & ~new_map;
  assign pix_acc = datain_valid & pixel_datain_tag & pixel_datain_rdy & ~new_map;
  assign seq_cnt_n = seq_cnt + 16'(seq_acc);
  assign pix_cnt_n = pix_cnt + 16'(pix_acc);
  assign col_inc = col_cnt + 16'd1;
  assign row_hit = pix_acc && col_inc == row_len_q;
  assign seq_nxt = new_map ? 16'd0 : seq_cnt_n;
  assign pix_nxt = new_map ? 16'd0 : pix_cnt_n;
  assign seq_rdy_n = state_n == SEQ && {16'd0, seq_nxt} < 32'(C_BRAM_DEPTH);
  assign pix_rdy_n = state_n == PIX && {16'd0, pix_nxt} < 32'(C_BRAM_DEPTH);
  assign cfg_out = {out_rows_q, out_cols_q};
  always_comb begin
    state_n = state;
    if (new_map) state_n = (seq_full_count_cfg == 16'd0) ? PIX : SEQ;
    else if (state == SEQ && seq_cnt_n == seq_full_q) state_n = PIX;
    else if (state == PIX && {16'd0, pix_cnt_n} == pix_total_q) state_n = DONE;
  end
  always_ff @(posedge clk_500MHz or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk_500MHz or posedge rst)
    if (rst) begin
      seq_cnt <= '0;
      pix_cnt <= '0;
      col_cnt <= '0;
      seq_full_q <= '0;
      row_len_q <= '0;
      out_rows_q <= '0;
      out_cols_q <= '0;
      pix_total_q <= '0;
      seq_datain_rdy <= 1'b0;
      pixel_datain_rdy <= 1'b0;
      row_done <= 1'b0;
      map_loaded <= 1'b0;
    end else begin
      seq_datain_rdy <= seq_rdy_n;
      pixel_datain_rdy <= pix_rdy_n;
      map_loaded <= state_n == DONE;
      if (new_map) begin
        seq_cnt <= '0;
        pix_cnt <= '0;
        col_cnt <= '0;
        row_done <= 1'b0;
        seq_full_q <= seq_full_count_cfg;
        row_len_q <= row_matric_done_count_cfg;
        out_rows_q <= num_output_rows_cfg;
        out_cols_q <= num_output_cols_cfg;
        pix_total_q <= ({16'd0, num_input_rows_cfg} + 32'd1) * ({16'd0, num_input_cols_cfg} + 32'd1);
      end else begin
        seq_cnt <= seq_cnt_n;
        pix_cnt <= pix_cnt_n;
        row_done <= row_hit;
        if (pix_acc) col_cnt <= row_hit ? 16'd0 : col_inc;
      end
    end
  cnn_octo_sdp_bram #(.W(C_SEQ_DATA_WIDTH), .D(C_BRAM_DEPTH)) u_seq_buf (
    .clk_500MHz(clk_500MHz),
    .rst(rst),
    .we(seq_acc),
    .wa(seq_cnt[AW-1:0]),
    .wd(datain[C_SEQ_DATA_WIDTH-1:0]),
    .ra(seq_rd_addr),
    .rd(seq_rd_data)
  );
  cnn_octo_sdp_bram #(.W(C_PIXEL_WIDTH), .D(C_BRAM_DEPTH)) u_pix_buf (
    .clk_500MHz(clk_500MHz),
    .rst(rst),
    .we(pix_acc),
    .wa(pix_cnt[AW-1:0]),
    .wd(datain),
    .ra(pix_rd_addr),
    .rd(pix_rd_data)
  );
endmodule

// File: tb/tb_cnn_octo_map_loader.sv
// tb_cnn_octo_map_loader: directed self-checking bench for the map loader
module tb_cnn_octo_map_loader;
  logic clk_500MHz = 1'b0;
  logic rst = 1'b1;
  logic new_map = 1'b0;
  logic [15:0] num_input_rows_cfg = 16'd9;
  logic [15:0] num_input_cols_cfg = 16'd9;
  logic [15:0] num_output_rows_cfg = 16'd7;
  logic [15:0] num_output_cols_cfg = 16'd7;
  logic [15:0] seq_full_count_cfg = 16'd40;
  logic [15:0] row_matric_done_count_cfg = 16'd10;
  logic pixel_datain_tag = 1'b0;
  logic seq_datain_tag = 1'b0;
  logic datain_valid = 1'b0;
  logic [15:0] datain = 16'd0;
  logic [9:0] seq_rd_addr = 10'd0;
  logic [9:0] pix_rd_addr = 10'd0;
  logic pixel_datain_rdy, seq_datain_rdy, row_done, map_loaded;
  logic [12:0] seq_rd_data;
  logic [15:0] pix_rd_data;
  logic [31:0] cfg_out;
  int checks = 0;
  int errors = 0;
  int row_pulses = 0;
  logic [12:0] seq_ref [40];
  logic [15:0] pix_ref [100];
  logic [15:0] old45;
  cnn_octo_map_loader dut (
    .clk_500MHz(clk_500MHz),
    .rst(rst),
    .new_map(new_map),
    .num_input_rows_cfg(num_input_rows_cfg),
    .num_input_cols_cfg(num_input_cols_cfg),
    .num_output_rows_cfg(num_output_rows_cfg),
    .num_output_cols_cfg(num_output_cols_cfg),
    .seq_full_count_cfg(seq_full_count_cfg),
    .row_matric_done_count_cfg(row_matric_done_count_cfg),
    .pixel_datain_tag(pixel_datain_tag),
    .pixel_datain_rdy(pixel_datain_rdy),
    .seq_datain_tag(seq_datain_tag),
    .seq_datain_rdy(seq_datain_rdy),
    .datain(datain),
    .datain_valid(datain_valid),
    .row_done(row_done),
    .map_loaded(map_loaded),
    .seq_rd_addr(seq_rd_addr),
    .seq_rd_data(seq_rd_data),
    .pix_rd_addr(pix_rd_addr),
    .pix_rd_data(pix_rd_data),
    .cfg_out(cfg_out)
  );
  always #5 clk_500MHz = ~clk_500MHz;
  always @(negedge clk_500MHz) if (row_done) row_pulses = row_pulses + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic is_pix, input logic [15:0] d);
    int n;
    n = 0;
    datain = d;
    pixel_datain_tag = is_pix;
    seq_datain_tag = !is_pix;
    datain_valid = 1'b1;
    while (!(is_pix ? pixel_datain_rdy : seq_datain_rdy) && n < 20) begin
      @(negedge clk_500MHz);
      n++;
    end
    chk("accept_wait", 32'(n < 20), 32'd1);
    @(negedge clk_500MHz);
  endtask
  task automatic pulse_new_map();
    new_map = 1'b1;
    @(negedge clk_500MHz);
    new_map = 1'b0;
    datain_valid = 1'b0;
  endtask
  task automatic rd_seq(input int a, input logic [12:0] e);
    seq_rd_addr = 10'(a);
    @(negedge clk_500MHz);
    chk("seq_buf", 32'(seq_rd_data), 32'(e));
  endtask
  task automatic rd_pix(input int a, input logic [15:0] e);
    pix_rd_addr = 10'(a);
    @(negedge clk_500MHz);
    chk("pix_buf", 32'(pix_rd_data), 32'(e));
  endtask
  task automatic send_all_seq();
    for (int i = 0; i < 40; i++) send(1'b0, {3'b101, seq_ref[i]});
    datain_valid = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 40; i++) seq_ref[i] = 13'(i * 37 + 5);
    seq_ref[0] = 13'h0C00;
    seq_ref[4] = 13'h1202;
    #20;
    chk("rst_seq_rdy", 32'(seq_datain_rdy), 32'd0);
    chk("rst_pix_rdy", 32'(pixel_datain_rdy), 32'd0);
    chk("rst_map_loaded", 32'(map_loaded), 32'd0);
    chk("rst_row_done", 32'(row_done), 32'd0);
    chk("rst_seq_rd", 32'(seq_rd_data), 32'd0);
    chk("rst_pix_rd", 32'(pix_rd_data), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk_500MHz);
    chk("idle_seq_rdy", 32'(seq_datain_rdy), 32'd0);
    pulse_new_map();
    chk("seq_rdy_up", 32'(seq_datain_rdy), 32'd1);
    chk("seq_pix_rdy", 32'(pixel_datain_rdy), 32'd0);
    chk("cfg_out", cfg_out, 32'h0007_0007);
    for (int i = 0; i < 20; i++) send(1'b0, {3'b101, seq_ref[i]});
    datain_valid = 1'b0;
    datain = 16'hFFFF;
    repeat (3) @(negedge clk_500MHz);
    chk("stall_seq_rdy", 32'(seq_datain_rdy), 32'd1);
    seq_datain_tag = 1'b0;
    pixel_datain_tag = 1'b1;
    datain = 16'h1ABC;
    datain_valid = 1'b1;
    repeat (3) @(negedge clk_500MHz);
    chk("wrongtag_seq_rdy", 32'(seq_datain_rdy), 32'd1);
    chk("wrongtag_pix_rdy", 32'(pixel_datain_rdy), 32'd0);
    for (int i = 20; i < 39; i++) send(1'b0, {3'b101, seq_ref[i]});
    chk("seq_rdy_39", 32'(seq_datain_rdy), 32'd1);
    send(1'b0, {3'b101, seq_ref[39]});
    datain_valid = 1'b0;
    chk("seq_rdy_40", 32'(seq_datain_rdy), 32'd0);
    chk("pix_rdy_up", 32'(pixel_datain_rdy), 32'd1);
    row_pulses = 0;
    for (int k = 0; k < 100; k++) pix_ref[k] = 16'($urandom_range(10, 1));
    for (int k = 0; k < 99; k++) send(1'b1, pix_ref[k]);
    chk("map_loaded_99", 32'(map_loaded), 32'd0);
    send(1'b1, pix_ref[99]);
    datain_valid = 1'b0;
    chk("map_loaded_100", 32'(map_loaded), 32'd1);
    chk("done_pix_rdy", 32'(pixel_datain_rdy), 32'd0);
    chk("done_seq_rdy", 32'(seq_datain_rdy), 32'd0);
    repeat (2) @(negedge clk_500MHz);
    chk("row_pulses", 32'(row_pulses), 32'd10);
    rd_seq(0, 13'h0C00);
    rd_seq(4, 13'h1202);
    rd_seq(20, seq_ref[20]);
    rd_seq(39, seq_ref[39]);
    for (int k = 0; k < 100; k++) rd_pix(k, pix_ref[k]);
    old45 = pix_ref[45];
    pulse_new_map();
    chk("rel_map_loaded", 32'(map_loaded), 32'd0);
    chk("rel_seq_rdy", 32'(seq_datain_rdy), 32'd1);
    send_all_seq();
    for (int k = 0; k < 45; k++) send(1'b1, 16'h0100 + 16'(k));
    pulse_new_map();
    chk("restart_seq_rdy", 32'(seq_datain_rdy), 32'd1);
    chk("restart_pix_rdy", 32'(pixel_datain_rdy), 32'd0);
    chk("restart_map_loaded", 32'(map_loaded), 32'd0);
    rd_pix(0, 16'h0100);
    rd_pix(44, 16'h012C);
    rd_pix(45, old45);
    row_pulses = 0;
    send_all_seq();
    chk("reload_pix_rdy", 32'(pixel_datain_rdy), 32'd1);
    for (int k = 0; k < 100; k++) pix_ref[k] = 16'($urandom_range(10, 1)) + 16'h0200;
    for (int k = 0; k < 100; k++) send(1'b1, pix_ref[k]);
    datain_valid = 1'b0;
    chk("reload_map_loaded", 32'(map_loaded), 32'd1);
    repeat (2) @(negedge clk_500MHz);
    chk("reload_row_pulses", 32'(row_pulses), 32'd10);
    for (int k = 0; k < 100; k++) rd_pix(k, pix_ref[k]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
